alu_op_dispatcher: RTL and testbench

Sequential initiator for the 4-bit ALU function units: bitwise_and, bitwise_or, bitwise_xor and the adder.
- Accepts an operation request over a valid/ready handshake.
- Drives exactly one unit's enable with registered operands A/B.
- Captures that unit's result and returns it over a valid/ready response channel.
- Sits between the ALU control path and the combinational unit bank; it is the only driver of the units' enable and A/B inputs.

---
 rtl/alu_disp_pkg.sv | 26 ++
 rtl/alu_disp_opdec.sv | 30 +++
 rtl/alu_op_dispatcher.sv | 140 ++++++++++++++
 tb/tb_alu_op_dispatcher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// ---------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU operation dispatcher and the ALU select path:
//   - op-code constants for the attached function units
//   - FSM state encoding of the dispatcher
//   - default operand width / unit count / op-code width
// Optional feature macro used by the dispatcher: ALU_DISP_OPCOUNT_EN
// ---------------------------------------------------------------------------
package alu_disp_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_NUM_UNITS = 4;
    localparam int DEF_OPW       = 3;

    localparam logic [DEF_OPW-1:0] OP_AND = 3'd0;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'd1;
    localparam logic [DEF_OPW-1:0] OP_XOR = 3'd2;
    localparam logic [DEF_OPW-1:0] OP_ADD = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_disp_opdec.sv
// ---------------------------------------------------------------------------
// alu_disp_opdec
// Combinational op-code decoder: op -> one-hot unit enable plus illegal flag.
// Codes 0..NUM_UNITS-1 select the matching unit; anything else is illegal and
// yields an all-zero enable.
// Ports:
//   op       in   OPW        op code
//   onehot   out  NUM_UNITS  one-hot unit select (bit i = unit i)
//   illegal  out  1          op code has no attached unit
// ---------------------------------------------------------------------------
module alu_disp_opdec
    import alu_disp_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int OPW       = DEF_OPW
) (
    input  logic [OPW-1:0]       op,
    output logic [NUM_UNITS-1:0] onehot,
    output logic                 illegal
);

    always_comb begin
        onehot  = '0;
        illegal = (32'(op) >= NUM_UNITS);
        for (int i = 0; i < NUM_UNITS; i++) begin
            onehot[i] = (32'(op) == i);
        end
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// ---------------------------------------------------------------------------
// alu_op_dispatcher
// Sequential initiator for the ALU function-unit bank. Accepts one request,
// drives exactly one unit enable with registered operands for one cycle,
// captures that unit's result and returns it on a valid/ready response.
// One op in flight at a time: IDLE -> ISSUE -> RESP -> IDLE.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; req_op/req_a/req_b payload
//   unit_en               one-hot unit enable (registered)
//   unit_a/unit_b         registered operands shared by all units
//   unit_res              concatenated unit results, slice i = unit i
//   rsp_valid/rsp_ready   response handshake; rsp_data/rsp_err payload
//   op_count/err_count    (only with ALU_DISP_OPCOUNT_EN) saturating counts
//                         of good / illegal-op responses handed off
// ---------------------------------------------------------------------------
module alu_op_dispatcher
    import alu_disp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int OPW       = DEF_OPW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [OPW-1:0]             req_op,
    input  logic [WIDTH-1:0]           req_a,
    input  logic [WIDTH-1:0]           req_b,
    output logic [NUM_UNITS-1:0]       unit_en,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_err
`ifdef ALU_DISP_OPCOUNT_EN
    ,
    output logic [7:0]                 op_count,
    output logic [3:0]                 err_count
`endif
);

    state_t                 state;
    logic                   err_q;
    logic [NUM_UNITS-1:0]   dec_onehot;
    logic                   dec_illegal;
    logic [WIDTH-1:0]       sel_res;

    // Decode the incoming op so unit_en can be loaded on the accept edge and
    // is already a clean register output during ISSUE.
    alu_disp_opdec #(
        .NUM_UNITS (NUM_UNITS),
        .OPW       (OPW)
    ) u_opdec (
        .op      (req_op),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    // Result mux keyed by the registered enable: only the enabled slice can
    // reach rsp_data, so undriven (X) slices of disabled units never leak.
    always_comb begin
        sel_res = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_en[i]) begin
                sel_res = unit_res[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            unit_en   <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= ISSUE;
                        req_ready <= 1'b0;
                        unit_en   <= dec_onehot;
                        unit_a    <= req_a;
                        unit_b    <= req_b;
                        err_q     <= dec_illegal;
                    end
                end
                ISSUE: begin
                    // Units are combinational: result is valid at this edge.
                    state     <= RESP;
                    unit_en   <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_data  <= err_q ? '0 : sel_res;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    unit_en   <= '0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_DISP_OPCOUNT_EN
    // Counted on the response hand-off, so dropped (reset) ops never count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err) begin
                if (err_count != 4'd15) begin
                    err_count <= err_count + 4'd1;
                end
            end else if (op_count != 8'd255) begin
                op_count <= op_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
module tb_alu_op_dispatcher;
    import alu_disp_pkg::*;

    localparam int WIDTH     = 4;
    localparam int NUM_UNITS = 4;
    localparam int OPW       = 3;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       req_valid = 1'b0;
    logic                       req_ready;
    logic [OPW-1:0]             req_op = '0;
    logic [WIDTH-1:0]           req_a = '0;
    logic [WIDTH-1:0]           req_b = '0;
    logic [NUM_UNITS-1:0]       unit_en;
    logic [WIDTH-1:0]           unit_a;
    logic [WIDTH-1:0]           unit_b;
    logic [NUM_UNITS*WIDTH-1:0] unit_res;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b0;
    logic [WIDTH-1:0]           rsp_data;
    logic                       rsp_err;
`ifdef ALU_DISP_OPCOUNT_EN
    logic [7:0]                 op_count;
    logic [3:0]                 err_count;
`endif

    int errors = 0;
    int checks = 0;
    int ok_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(
        .WIDTH     (WIDTH),
        .NUM_UNITS (NUM_UNITS),
        .OPW       (OPW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .unit_en   (unit_en),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_res  (unit_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef ALU_DISP_OPCOUNT_EN
        ,
        .op_count  (op_count),
        .err_count (err_count)
`endif
    );

    // Unit bank model: enabled units compute, disabled units drive garbage.
    logic [3:0] junk = 4'h9;
    always @(posedge clk) junk <= 4'($urandom);

    always_comb begin
        unit_res = {4{junk}};
        if (unit_en[0]) unit_res[3:0]   = unit_a & unit_b;
        if (unit_en[1]) unit_res[7:4]   = unit_a | unit_b;
        if (unit_en[2]) unit_res[11:8]  = unit_a ^ unit_b;
        if (unit_en[3]) unit_res[15:12] = 4'(unit_a + unit_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: {err, data} for one op, straight from the unit definitions.
    function automatic logic [4:0] ref_rsp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, a ^ b};
            3'd3:    return {1'b0, 4'(a + b)};
            default: return 5'h10;
        endcase
    endfunction

    function automatic logic [3:0] ref_en(input logic [2:0] op);
        if (op < 3'd4) return 4'b0001 << op;
        return 4'b0000;
    endfunction

    task automatic check_counters();
`ifdef ALU_DISP_OPCOUNT_EN
        check("op_count", 32'(op_count), 32'((ok_cnt > 255) ? 255 : ok_cnt));
        check("err_count", 32'(err_count), 32'((err_cnt > 15) ? 15 : err_cnt));
`endif
    endtask

    // One full transaction with `hold` cycles of response backpressure.
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int hold);
        logic [4:0] e;
        e = ref_rsp(op, a, b);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = 4'($urandom);
        req_b = 4'($urandom);
        check("issue_en", 32'(unit_en), 32'(ref_en(op)));
        check("issue_a", 32'(unit_a), 32'(a));
        check("issue_b", 32'(unit_b), 32'(b));
        check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        check("issue_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_data", 32'(rsp_data), 32'(e[3:0]));
        check("resp_err", 32'(rsp_err), 32'(e[4]));
        check("resp_en", 32'(unit_en), 32'd0);
        check("resp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(e[3:0]));
            check("hold_err", 32'(rsp_err), 32'(e[4]));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_valid", 32'(rsp_valid), 32'd0);
        check("done_req_ready", 32'(req_ready), 32'd1);
        if (e[4]) err_cnt++;
        else ok_cnt++;
        check_counters();
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_unit_en", 32'(unit_en), 32'd0);
        check("rst_unit_a", 32'(unit_a), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check_counters();

        // Directed: OR, AND with backpressure, illegal op
        do_op(3'd1, 4'b1010, 4'b0101, 0);
        do_op(3'd0, 4'hC, 4'hA, 5);
        do_op(3'd5, 4'h3, 4'h3, 0);

        // Reset asserted while in RESP
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 4'hA; req_b = 4'h5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_data", 32'(rsp_data), 32'hF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_en", 32'(unit_en), 32'd0);
        check("mid_rst_data", 32'(rsp_data), 32'd0);
        check("mid_rst_a", 32'(unit_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ok_cnt = 0;
        err_cnt = 0;
        check_counters();
        do_op(3'd1, 4'hA, 4'h5, 0);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 4'h1; req_b = 4'h2;
        @(posedge clk); #1;
        req_op = 3'd2; req_a = 4'hF; req_b = 4'h3;
        check("b2b_first_en", 32'(unit_en), 32'b0010);
        @(posedge clk); #1;
        check("b2b_first_data", 32'(rsp_data), 32'h3);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("b2b_blocked_ready", 32'(req_ready), 32'd0);
            check("b2b_blocked_en", 32'(unit_en), 32'd0);
            check("b2b_blocked_a", 32'(unit_a), 32'h1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ok_cnt++;
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_second_en", 32'(unit_en), 32'b0100);
        check("b2b_second_a", 32'(unit_a), 32'hF);
        @(posedge clk); #1;
        check("b2b_second_valid", 32'(rsp_valid), 32'd1);
        check("b2b_second_data", 32'(rsp_data), 32'hC);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ok_cnt++;
        check_counters();

        // Randomized mix of legal and illegal ops with random backpressure
        for (int n = 0; n < 60; n++) begin
            do_op(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        // Enough legal ops to saturate the good-op counter
        for (int n = 0; n < 260; n++) begin
            do_op(3'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
